elink_frame_assembler: RTL and testbench
========================================

Name: elink_frame_assembler

Overview:
- Sits directly downstream of the E-link 8b10b decoder, on the receive side of the MOPSHUB/EMCI path.
- Consumes decoded bytes tagged with delimiter codes.
- Rebuilds each SOP…EOP packet into one fixed-width frame (76-bit MOPSHUB/CAN frame by default) and presents it with a valid/ready handshake to the FIFO writer.
- Detects and counts malformed packets.

Parameters:
- N_BYTES, 10, data bytes expected between SOP and EOP.
- FRAME_W, 76, output frame width; must satisfy FRAME_W <= 8*N_BYTES.
- CNT_W, 16, width of the good-frame counter.

Ports:
- bitCLKx4  in  1  clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high reset.
- dec_data  in  8  decoded byte.
- dec_code  in  2  delimiter tag: 00 data, 01 EOP, 10 SOP, 11 comma/idle.
- dec_rdy  in  1  one-cycle strobe; dec_data/dec_code are valid this cycle.
- frame_data  out  FRAME_W  assembled frame.
- frame_valid  out  1  frame_data holds an unconsumed frame.
- frame_ready  in  1  consumer accepts the frame when frame_valid&&frame_ready.
- err_short  out  1  pulse: packet terminated (EOP or new SOP) with fewer than N_BYTES bytes.
- err_long  out  1  pulse: more than N_BYTES data bytes before EOP.
- err_ovf  out  1  pulse: completed frame dropped because the output register was occupied.
- frame_cnt  out  CNT_W  frames delivered; wraps.
- err_cnt  out  8  total error pulses; saturates at 255.

Behaviour:
- Reset (async assert, sync release): state=IDLE, byte counter=0, shift register=0. frame_data=0, frame_valid=0, all err_* pulses=0, frame_cnt=0, err_cnt=0.
- Only cycles with dec_rdy=1 are processed. Comma (11) is ignored in every state.

State machine:
- IDLE: SOP → COLLECT, counter=0. Data or EOP bytes are ignored, with no error.
- COLLECT:
  - Data byte with counter<N_BYTES: shift into register (first byte ends up most significant), counter+1.
  - Data byte with counter==N_BYTES: err_long pulse → DISCARD.
  - EOP with counter==N_BYTES: frame complete → IDLE.
  - EOP with counter<N_BYTES: err_short pulse → IDLE, bytes dropped.
  - SOP: err_short pulse, counter=0, stay in COLLECT (restart).
- DISCARD: wait for EOP → IDLE, or SOP → COLLECT with counter=0. Data bytes are ignored. No further error pulses.

Frame completion:
- Frame = 8*N_BYTES-bit concatenation {b0,…,b(N-1)}, truncated to its FRAME_W LSBs. With defaults, the top 4 bits of b0 are dropped.
- frame_data/frame_valid update on the clock edge that processes EOP. frame_valid is high the cycle after EOP is presented.
- Output register is free when frame_valid==0, or when frame_ready==1 in the completion cycle. In that case the new frame loads, frame_valid stays/goes 1, and frame_cnt increments on load.
- Otherwise the new frame is dropped, err_ovf pulses, and the held frame_data is unchanged.
- frame_valid falls on the edge after a handshake unless a new frame loads on that same edge.
- frame_data is stable while frame_valid=1 and frame_ready=0.

Counters and pulses:
- Every err_* pulse lasts exactly 1 cycle, one cycle after the offending byte is presented.
- err_cnt increments by the number of simultaneous pulses (at most 1 by construction) and saturates at 255.
- frame_cnt wraps at 2^CNT_W.

Reset mid-packet: any partial frame and any pending output frame are lost; no error pulses are generated.

Assembly continues in COLLECT regardless of the frame_valid/frame_ready state.

Test Plan:
- Nominal: SOP, bytes 0x01..0x0A, EOP, frame_ready=1 → one frame_valid cycle, frame_data=76'h1_0203_0405_0607_0809_0A (lower 76 of 0x0102…0A), frame_cnt=1, no err_*.
- Short: SOP, 5 data bytes, EOP → err_short pulse, err_cnt=1, frame_valid stays 0. Then a valid packet → delivered.
- Long and restart: SOP, 11 data bytes → err_long after the 11th byte. Extra bytes ignored until EOP. Next SOP+10+EOP delivered. Separately, SOP, 3 bytes, SOP, 10 bytes, EOP → one err_short and one good frame.
- Backpressure: frame_ready=0, send two good packets → first frame held unchanged, err_ovf pulse on the second EOP, frame_cnt=1. Raise ready → frame_valid drops next cycle.
- Back-to-back handshake: frame_valid=1 and frame_ready=1 on the same cycle a second EOP completes → second frame loads, frame_valid stays 1, frame_cnt=2, no err_ovf.
- Commas and async reset: commas interleaved between every byte give the same result as nominal. Assert reset after SOP+4 bytes → all outputs 0 immediately (asynchronously). Following good packet delivered with frame_cnt=1.

Source files
------------

// File: rtl/elink_frame_assembler.sv
// Rebuilds SOP..EOP byte packets from the E-link 8b10b decoder into fixed-width
// frames with a valid/ready output register and malformed-packet accounting.
module elink_frame_assembler #(
  parameter int N_BYTES = 10,
  parameter int FRAME_W = 76,
  parameter int CNT_W   = 16
) (
  input  logic               bitCLKx4,
  input  logic               reset,
  input  logic [7:0]         dec_data,
  input  logic [1:0]         dec_code,
  input  logic               dec_rdy,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               err_short,
  output logic               err_long,
  output logic               err_ovf,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [7:0]         err_cnt
);

  localparam int CW = $clog2(N_BYTES + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N_BYTES);
  localparam logic [1:0] C_DATA = 2'b00;
  localparam logic [1:0] C_EOP  = 2'b01;
  localparam logic [1:0] C_SOP  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISCARD} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [FRAME_W-1:0]   shift_q;
  logic [FRAME_W-1:0]   shift_d;
  logic [FRAME_W-1:0]   frame_data_q;
  logic                 frame_valid_q;
  logic                 err_short_q;
  logic                 err_long_q;
  logic                 err_ovf_q;
  logic [CNT_W-1:0]     frame_cnt_q;
  logic [7:0]           err_cnt_q;
  logic [7:0]           err_cnt_d;

  logic is_data;
  logic is_eop;
  logic is_sop;
  logic cnt_full;
  logic out_free;

  assign is_data  = dec_rdy && (dec_code == C_DATA);
  assign is_eop   = dec_rdy && (dec_code == C_EOP);
  assign is_sop   = dec_rdy && (dec_code == C_SOP);
  assign cnt_full = (cnt_q == N_CNT);
  assign out_free = !frame_valid_q || frame_ready;

  // Register is only FRAME_W wide: shifting naturally drops the leading bits
  // that would be truncated from the full 8*N_BYTES concatenation anyway.
  assign shift_d   = FRAME_W'({shift_q, dec_data});
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge bitCLKx4 or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      err_ovf_q     <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      if (frame_valid_q && frame_ready) begin
        frame_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (is_sop) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
          end
        end
        S_COLLECT: begin
          if (is_data) begin
            if (!cnt_full) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + CW'(1);
            end else begin
              err_long_q <= 1'b1;
              err_cnt_q  <= err_cnt_d;
              state_q    <= S_DISCARD;
            end
          end else if (is_eop) begin
            state_q <= S_IDLE;
            if (!cnt_full) begin
              err_short_q <= 1'b1;
              err_cnt_q   <= err_cnt_d;
            end else if (out_free) begin
              // A load on the handshake edge overrides the valid clear above.
              frame_data_q  <= shift_q;
              frame_valid_q <= 1'b1;
              frame_cnt_q   <= frame_cnt_q + CNT_W'(1);
            end else begin
              err_ovf_q <= 1'b1;
              err_cnt_q <= err_cnt_d;
            end
          end else if (is_sop) begin
            err_short_q <= 1'b1;
            err_cnt_q   <= err_cnt_d;
            cnt_q       <= '0;
          end
        end
        S_DISCARD: begin
          if (is_eop) begin
            state_q <= S_IDLE;
          end else if (is_sop) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign err_ovf     = err_ovf_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_elink_frame_assembler.sv
// Directed bench for elink_frame_assembler: nominal, short, long, restart,
// backpressure, back-to-back handshake, commas and asynchronous reset.
module tb_elink_frame_assembler;

  localparam logic [1:0] C_DATA  = 2'b00;
  localparam logic [1:0] C_EOP   = 2'b01;
  localparam logic [1:0] C_SOP   = 2'b10;
  localparam logic [1:0] C_COMMA = 2'b11;

  localparam logic [75:0] F1 = 76'h102030405060708090A;
  localparam logic [75:0] F2 = 76'h112131415161718191A;
  localparam logic [75:0] F3 = 76'h122232425262728292A;
  localparam logic [75:0] F4 = 76'h132333435363738393A;

  logic        bitCLKx4;
  logic        reset;
  logic [7:0]  dec_data;
  logic [1:0]  dec_code;
  logic        dec_rdy;
  logic [75:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        err_short;
  logic        err_long;
  logic        err_ovf;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_short = 0;
  int n_long  = 0;
  int n_ovf   = 0;

  elink_frame_assembler dut (
    .bitCLKx4    (bitCLKx4),
    .reset       (reset),
    .dec_data    (dec_data),
    .dec_code    (dec_code),
    .dec_rdy     (dec_rdy),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .err_short   (err_short),
    .err_long    (err_long),
    .err_ovf     (err_ovf),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  initial bitCLKx4 = 1'b0;
  always #5 bitCLKx4 = ~bitCLKx4;

  always @(negedge bitCLKx4) begin
    if (err_short) n_short++;
    if (err_long)  n_long++;
    if (err_ovf)   n_ovf++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one byte at a falling edge; returns at the next falling edge.
  task automatic send(input logic [1:0] c, input logic [7:0] d);
    dec_rdy  = 1'b1;
    dec_code = c;
    dec_data = d;
    @(negedge bitCLKx4);
    dec_rdy  = 1'b0;
  endtask

  task automatic idle();
    dec_rdy = 1'b0;
    @(negedge bitCLKx4);
  endtask

  task automatic pkt(input logic [7:0] s, input int n);
    send(C_SOP, 8'h00);
    for (int i = 0; i < n; i++) send(C_DATA, s + 8'(i));
    send(C_EOP, 8'h00);
  endtask

  initial begin
    reset       = 1'b1;
    dec_rdy     = 1'b0;
    dec_code    = C_COMMA;
    dec_data    = 8'h00;
    frame_ready = 1'b1;
    repeat (3) @(negedge bitCLKx4);
    check("rst_valid", 80'(frame_valid), 80'(0));
    check("rst_data",  80'(frame_data),  80'(0));
    check("rst_fcnt",  80'(frame_cnt),   80'(0));
    check("rst_ecnt",  80'(err_cnt),     80'(0));
    reset = 1'b0;
    $display("[TB] reset released");

    pkt(8'h01, 10);
    check("nom_valid", 80'(frame_valid), 80'(1));
    check("nom_data",  80'(frame_data),  80'(F1));
    check("nom_fcnt",  80'(frame_cnt),   80'(1));
    idle();
    check("nom_drop",  80'(frame_valid), 80'(0));
    check("nom_ecnt",  80'(err_cnt),     80'(0));
    check("nom_noerr", 80'(n_short + n_long + n_ovf), 80'(0));
    $display("[TB] nominal packet done");

    pkt(8'h40, 5);
    idle();
    check("short_pulses", 80'(n_short),    80'(1));
    check("short_ecnt",   80'(err_cnt),    80'(1));
    check("short_valid",  80'(frame_valid), 80'(0));
    pkt(8'h11, 10);
    check("short_next_data", 80'(frame_data), 80'(F2));
    check("short_next_fcnt", 80'(frame_cnt),  80'(2));
    idle();
    $display("[TB] short packet done");

    send(C_SOP, 8'h00);
    for (int i = 0; i < 11; i++) send(C_DATA, 8'h50 + 8'(i));
    check("long_pulse", 80'(err_long), 80'(1));
    send(C_DATA, 8'h99);
    check("long_once", 80'(err_long), 80'(0));
    send(C_DATA, 8'h98);
    send(C_EOP, 8'h00);
    idle();
    check("long_pulses", 80'(n_long),      80'(1));
    check("long_valid",  80'(frame_valid), 80'(0));
    check("long_ecnt",   80'(err_cnt),     80'(2));
    pkt(8'h21, 10);
    check("long_next_data", 80'(frame_data), 80'(F3));
    check("long_next_fcnt", 80'(frame_cnt),  80'(3));
    idle();
    $display("[TB] long packet done");

    send(C_SOP, 8'h00);
    for (int i = 0; i < 3; i++) send(C_DATA, 8'h60 + 8'(i));
    pkt(8'h31, 10);
    check("rst_pkt_data", 80'(frame_data), 80'(F4));
    check("rst_pkt_fcnt", 80'(frame_cnt),  80'(4));
    idle();
    check("rst_pkt_short", 80'(n_short), 80'(2));
    check("rst_pkt_ecnt",  80'(err_cnt), 80'(3));
    $display("[TB] restart packet done");

    frame_ready = 1'b0;
    pkt(8'h01, 10);
    check("bp_first_data", 80'(frame_data), 80'(F1));
    check("bp_first_fcnt", 80'(frame_cnt),  80'(5));
    pkt(8'h11, 10);
    check("bp_ovf_pulse", 80'(err_ovf),     80'(1));
    check("bp_held_data", 80'(frame_data),  80'(F1));
    check("bp_held_fcnt", 80'(frame_cnt),   80'(5));
    check("bp_held_valid", 80'(frame_valid), 80'(1));
    idle();
    check("bp_ovf_count", 80'(n_ovf),   80'(1));
    check("bp_ecnt",      80'(err_cnt), 80'(4));
    frame_ready = 1'b1;
    idle();
    check("bp_release", 80'(frame_valid), 80'(0));
    $display("[TB] backpressure done");

    frame_ready = 1'b0;
    pkt(8'h21, 10);
    check("b2b_first_fcnt", 80'(frame_cnt), 80'(6));
    send(C_SOP, 8'h00);
    for (int i = 0; i < 10; i++) send(C_DATA, 8'h31 + 8'(i));
    frame_ready = 1'b1;
    send(C_EOP, 8'h00);
    check("b2b_valid", 80'(frame_valid), 80'(1));
    check("b2b_data",  80'(frame_data),  80'(F4));
    check("b2b_fcnt",  80'(frame_cnt),   80'(7));
    check("b2b_noovf", 80'(err_ovf),     80'(0));
    idle();
    check("b2b_drop",  80'(frame_valid), 80'(0));
    check("b2b_ovf_count", 80'(n_ovf),   80'(1));
    $display("[TB] back-to-back handshake done");

    send(C_DATA, 8'h77);
    send(C_EOP, 8'h00);
    send(C_COMMA, 8'hFF);
    send(C_SOP, 8'h00);
    send(C_COMMA, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      send(C_DATA, 8'h01 + 8'(i));
      send(C_COMMA, 8'hBC);
    end
    send(C_EOP, 8'h00);
    check("comma_data", 80'(frame_data), 80'(F1));
    check("comma_fcnt", 80'(frame_cnt),  80'(8));
    idle();
    check("comma_ecnt",  80'(err_cnt), 80'(4));
    check("comma_short", 80'(n_short), 80'(2));
    $display("[TB] comma interleave done");

    frame_ready = 1'b0;
    pkt(8'h11, 10);
    check("pre_rst_fcnt", 80'(frame_cnt), 80'(9));
    send(C_SOP, 8'h00);
    for (int i = 0; i < 4; i++) send(C_DATA, 8'h70 + 8'(i));
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 80'(frame_valid), 80'(0));
    check("arst_data",  80'(frame_data),  80'(0));
    check("arst_fcnt",  80'(frame_cnt),   80'(0));
    check("arst_ecnt",  80'(err_cnt),     80'(0));
    @(negedge bitCLKx4);
    reset       = 1'b0;
    frame_ready = 1'b1;
    pkt(8'h21, 10);
    check("post_rst_valid", 80'(frame_valid), 80'(1));
    check("post_rst_data",  80'(frame_data),  80'(F3));
    check("post_rst_fcnt",  80'(frame_cnt),   80'(1));
    idle();
    check("post_rst_ecnt",  80'(err_cnt), 80'(0));
    check("post_rst_short", 80'(n_short), 80'(2));
    $display("[TB] async reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
